ram_bus_master: RTL and testbench



---
 rtl/ram_bus_master.sv | 115 +++++++++++
 tb/tb_ram_bus_master.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bus_master.sv
// ram_bus_master: initiator side of the 16-bit RAM bus.
// Takes one CPU word/byte request per req/ack handshake and runs one RAM cycle for it.
// Ports: clk, reset (sync, active high);
//        CPU side  req, req_we, req_byte, req_addr, req_wdata -> ack, rdata, err_odd, err_nxm;
//        RAM side  ram_addr, ram_di, ram_ce_n, ram_we_n, ram_byte_op <- ram_do.
// Optional build macro RAM_BUS_BYTE_SEXT_EN: byte reads sign-extend ram_do[7:0] into rdata.
module ram_bus_master #(
    parameter int WAIT_CYCLES = 0,
    parameter int MEM_SIZE    = 65536
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        req_we,
    input  logic        req_byte,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        ack,
    output logic [15:0] rdata,
    output logic        err_odd,
    output logic        err_nxm,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_di,
    input  logic [15:0] ram_do,
    output logic        ram_ce_n,
    output logic        ram_we_n,
    output logic        ram_byte_op
);

    localparam logic [1:0]  S_IDLE    = 2'd0;
    localparam logic [1:0]  S_ACCESS  = 2'd1;
    localparam logic [1:0]  S_DONE    = 2'd2;
    // 17 bits so that MEM_SIZE = 65536 means "every address exists"
    localparam logic [16:0] MEM_LIM   = 17'(MEM_SIZE);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    logic [1:0]  state;
    logic [3:0]  wait_cnt;
    logic        we_q;
    logic        odd;
    logic        nxm;
    logic [15:0] rd_val;

    assign odd = ~req_byte & req_addr[0];
    assign nxm = {1'b0, req_addr} >= MEM_LIM;

    always_comb begin
        rd_val = ram_do;
`ifdef RAM_BUS_BYTE_SEXT_EN
        if (ram_byte_op)
            rd_val = {{8{ram_do[7]}}, ram_do[7:0]};
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            wait_cnt    <= 4'd0;
            we_q        <= 1'b0;
            ack         <= 1'b0;
            rdata       <= 16'd0;
            err_odd     <= 1'b0;
            err_nxm     <= 1'b0;
            ram_addr    <= 16'd0;
            ram_di      <= 16'd0;
            ram_ce_n    <= 1'b1;
            ram_we_n    <= 1'b1;
            ram_byte_op <= 1'b0;
        end else begin
            ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        we_q    <= req_we;
                        err_odd <= odd;
                        // odd-address fault wins over non-existent memory
                        err_nxm <= ~odd & nxm;
                        if (odd | nxm) begin
                            state <= S_DONE;
                        end else begin
                            ram_addr    <= req_addr;
                            ram_di      <= req_wdata;
                            ram_byte_op <= req_byte;
                            ram_ce_n    <= 1'b0;
                            // with no wait states the first ACCESS cycle is the final one
                            ram_we_n    <= ~(req_we && (WAIT_INIT == 4'd0));
                            wait_cnt    <= WAIT_INIT;
                            state       <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    if (wait_cnt == 4'd0) begin
                        if (!we_q)
                            rdata <= rd_val;
                        ram_ce_n <= 1'b1;
                        ram_we_n <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                        // drop WE_N only for the last CE_N cycle: one write edge
                        if (wait_cnt == 4'd1)
                            ram_we_n <= ~we_q;
                    end
                end
                S_DONE: begin
                    ack   <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_bus_master.sv
// tb_ram_bus_master: directed bench for ram_bus_master with a behavioural RAM responder.
// Three instances (0: WAIT 0 / 4 KB, 1: WAIT 2, 2: WAIT 3) share the CPU stimulus and one RAM array.
module tb_ram_bus_master;

    typedef struct packed {
        logic [15:0] rd;
        logic        odd;
        logic        nxm;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        req_we;
    logic        req_byte;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  sel;

    logic [2:0]  req_v;
    logic [2:0]  ack_v;
    logic [2:0]  odd_v;
    logic [2:0]  nxm_v;
    logic [2:0]  ce_v;
    logic [2:0]  we_v;
    logic [2:0]  bop_v;
    logic [15:0] rdata_v [3];
    logic [15:0] addr_v  [3];
    logic [15:0] di_v    [3];
    logic [15:0] do_v    [3];

    logic [15:0] mem [32768];
    int          ce_cnt = 0;
    int          wr_cnt = 0;

    int   vectors = 0;
    int   errs    = 0;
    exp_t sbq [$];

`ifdef RAM_BUS_BYTE_SEXT_EN
    localparam logic [15:0] BYTE_FF = 16'o177777;
`else
    localparam logic [15:0] BYTE_FF = 16'o000377;
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_rd
        assign req_v[g] = req && (sel == 2'(g));
        assign do_v[g]  = bop_v[g]
            ? {8'h00, addr_v[g][0] ? mem[addr_v[g][15:1]][15:8]
                                   : mem[addr_v[g][15:1]][7:0]}
            : mem[addr_v[g][15:1]];
    end

    // responder: DI[7:0] goes to the addressed byte lane on byte writes
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!ce_v[i]) ce_cnt <= ce_cnt + 1;
            if (!ce_v[i] && !we_v[i]) begin
                wr_cnt <= wr_cnt + 1;
                if (!bop_v[i])
                    mem[addr_v[i][15:1]] <= di_v[i];
                else if (addr_v[i][0])
                    mem[addr_v[i][15:1]][15:8] <= di_v[i][7:0];
                else
                    mem[addr_v[i][15:1]][7:0] <= di_v[i][7:0];
            end
        end
    end

    ram_bus_master #(.WAIT_CYCLES(0), .MEM_SIZE(4096)) u_a (
        .clk(clk), .reset(reset), .req(req_v[0]), .req_we(req_we),
        .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
        .ack(ack_v[0]), .rdata(rdata_v[0]), .err_odd(odd_v[0]),
        .err_nxm(nxm_v[0]), .ram_addr(addr_v[0]), .ram_di(di_v[0]),
        .ram_do(do_v[0]), .ram_ce_n(ce_v[0]), .ram_we_n(we_v[0]),
        .ram_byte_op(bop_v[0]));

    ram_bus_master #(.WAIT_CYCLES(2)) u_c (
        .clk(clk), .reset(reset), .req(req_v[1]), .req_we(req_we),
        .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
        .ack(ack_v[1]), .rdata(rdata_v[1]), .err_odd(odd_v[1]),
        .err_nxm(nxm_v[1]), .ram_addr(addr_v[1]), .ram_di(di_v[1]),
        .ram_do(do_v[1]), .ram_ce_n(ce_v[1]), .ram_we_n(we_v[1]),
        .ram_byte_op(bop_v[1]));

    ram_bus_master #(.WAIT_CYCLES(3)) u_d (
        .clk(clk), .reset(reset), .req(req_v[2]), .req_we(req_we),
        .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
        .ack(ack_v[2]), .rdata(rdata_v[2]), .err_odd(odd_v[2]),
        .err_nxm(nxm_v[2]), .ram_addr(addr_v[2]), .ram_di(di_v[2]),
        .ram_do(do_v[2]), .ram_ce_n(ce_v[2]), .ram_we_n(we_v[2]),
        .ram_byte_op(bop_v[2]));

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // counts negedges until ack of the selected instance, bounded
    task automatic wait_ack(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack_v[sel] && n < 60);
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        chk({tag, " ack"}, 32'(ack_v[sel]), 32'd1);
        chk({tag, " sb"}, 32'(sbq.size() != 0), 32'd1);
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk({tag, " rdata"}, 32'(rdata_v[sel]), 32'(e.rd));
            chk({tag, " odd"}, 32'(odd_v[sel]), 32'(e.odd));
            chk({tag, " nxm"}, 32'(nxm_v[sel]), 32'(e.nxm));
        end
    endtask

    // one access; lat = posedges from the req-sampling edge to ack high
    task automatic access(input string tag, input logic [1:0] s,
                          input logic we, input logic byt,
                          input logic [15:0] a, input logic [15:0] wd,
                          input logic [15:0] erd, input logic eodd,
                          input logic enxm, input int lat,
                          input int ces, input int wrs);
        int n, c0, w0;
        sel       = s;
        req_we    = we;
        req_byte  = byt;
        req_addr  = a;
        req_wdata = wd;
        req       = 1'b1;
        c0        = ce_cnt;
        w0        = wr_cnt;
        sbq.push_back('{rd: erd, odd: eodd, nxm: enxm});
        wait_ack(n);
        req = 1'b0;
        chk({tag, " lat"}, 32'(n - 1), 32'(lat));
        sb_check(tag);
        chk({tag, " ce cycles"}, 32'(ce_cnt - c0), 32'(ces));
        chk({tag, " wr edges"}, 32'(wr_cnt - w0), 32'(wrs));
        @(negedge clk);
        chk({tag, " ack pulse"}, 32'(ack_v[s]), 32'd0);
    endtask

    initial begin
        int n, c0, w0;
        reset     = 1'b1;
        req       = 1'b0;
        req_we    = 1'b0;
        req_byte  = 1'b0;
        req_addr  = 16'd0;
        req_wdata = 16'd0;
        sel       = 2'd0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst ack", 32'(ack_v[i]), 32'd0);
            chk("rst ce_n", 32'(ce_v[i]), 32'd1);
            chk("rst we_n", 32'(we_v[i]), 32'd1);
            chk("rst rdata", 32'(rdata_v[i]), 32'd0);
            chk("rst errs", 32'({odd_v[i], nxm_v[i]}), 32'd0);
            chk("rst addr", 32'(addr_v[i]), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);

        // word write/read, no wait states
        access("wr w700", 2'd0, 1, 0, 16'o000700, 16'o123456,
               16'd0, 0, 0, 2, 1, 1);
        access("rd w700", 2'd0, 0, 0, 16'o000700, 16'd0,
               16'o123456, 0, 0, 2, 1, 0);
        // byte lanes
        access("wr b701", 2'd0, 1, 1, 16'o000701, 16'o000377,
               16'o123456, 0, 0, 2, 1, 1);
        access("rd w700b", 2'd0, 0, 0, 16'o000700, 16'd0,
               16'o177456, 0, 0, 2, 1, 0);
        access("wr b700", 2'd0, 1, 1, 16'o000700, 16'o000001,
               16'o177456, 0, 0, 2, 1, 1);
        access("rd w700c", 2'd0, 0, 0, 16'o000700, 16'd0,
               16'o177401, 0, 0, 2, 1, 0);
        access("rd b701", 2'd0, 0, 1, 16'o000701, 16'd0,
               BYTE_FF, 0, 0, 2, 1, 0);
        // error completions: no RAM cycle, rdata held
        access("odd 501", 2'd0, 0, 0, 16'o000501, 16'd0,
               BYTE_FF, 1, 0, 1, 0, 0);
        access("nxm 10000", 2'd0, 0, 0, 16'o010000, 16'd0,
               BYTE_FF, 0, 1, 1, 0, 0);
        access("odd+nxm", 2'd0, 1, 0, 16'o010001, 16'hdead,
               BYTE_FF, 1, 0, 1, 0, 0);
        access("wr 7776", 2'd0, 1, 0, 16'o007776, 16'h5a5a,
               BYTE_FF, 0, 0, 2, 1, 1);
        access("rd 7776", 2'd0, 0, 0, 16'o007776, 16'd0,
               16'h5a5a, 0, 0, 2, 1, 0);
        access("rd b7777", 2'd0, 0, 1, 16'o007777, 16'd0,
               16'h005a, 0, 0, 2, 1, 0);
        access("wr 1000", 2'd0, 1, 0, 16'o001000, 16'h1234,
               16'h005a, 0, 0, 2, 1, 1);
        access("wr 1002", 2'd0, 1, 0, 16'o001002, 16'hbeef,
               16'h005a, 0, 0, 2, 1, 1);

        // back-to-back reads, WAIT_CYCLES=2, req never dropped between them
        sel      = 2'd1;
        req_we   = 1'b0;
        req_byte = 1'b0;
        req_addr = 16'o001000;
        req      = 1'b1;
        c0       = ce_cnt;
        sbq.push_back('{rd: 16'h1234, odd: 1'b0, nxm: 1'b0});
        wait_ack(n);
        chk("b2b lat", 32'(n - 1), 32'd4);
        sb_check("b2b 1000");
        req_addr = 16'o001002;
        sbq.push_back('{rd: 16'hbeef, odd: 1'b0, nxm: 1'b0});
        wait_ack(n);
        req = 1'b0;
        chk("b2b period", 32'(n), 32'd5);
        sb_check("b2b 1002");
        chk("b2b ce cycles", 32'(ce_cnt - c0), 32'd6);
        @(negedge clk);
        chk("b2b ack pulse", 32'(ack_v[1]), 32'd0);

        // reset in the middle of a WAIT_CYCLES=3 write with req held
        access("d rd 700", 2'd2, 0, 0, 16'o000700, 16'd0,
               16'o177401, 0, 0, 5, 4, 0);
        sel       = 2'd2;
        req_we    = 1'b1;
        req_byte  = 1'b0;
        req_addr  = 16'o002000;
        req_wdata = 16'h0f0f;
        req       = 1'b1;
        w0        = wr_cnt;
        @(negedge clk);
        @(negedge clk);
        chk("mid ce_n", 32'(ce_v[2]), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("abort ce_n", 32'(ce_v[2]), 32'd1);
        chk("abort we_n", 32'(we_v[2]), 32'd1);
        chk("abort ack", 32'(ack_v[2]), 32'd0);
        chk("abort rdata", 32'(rdata_v[2]), 32'd0);
        chk("abort wr", 32'(wr_cnt - w0), 32'd0);
        reset = 1'b0;
        sbq.push_back('{rd: 16'd0, odd: 1'b0, nxm: 1'b0});
        wait_ack(n);
        req = 1'b0;
        chk("restart lat", 32'(n - 1), 32'd5);
        sb_check("restart");
        chk("restart wr", 32'(wr_cnt - w0), 32'd1);
        @(negedge clk);
        chk("restart ack pulse", 32'(ack_v[2]), 32'd0);
        @(negedge clk);
        chk("no residual ack", 32'(ack_v[2]), 32'd0);
        access("rd 2000", 2'd0, 0, 0, 16'o002000, 16'd0,
               16'h0f0f, 0, 0, 2, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
